sr_flag_bank: RTL and testbench
===============================

SR_FLAG_BANK -- requirements
Module: sr_flag_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the number of independent set/reset channels (1..64).
REQ-002 The block SHALL have parameter PRIORITY, default 0, meaning conflict resolution: 0 RESET_WINS, 1 SET_WINS, 2 HOLD, 3 TOGGLE.
REQ-003 The block SHALL have parameter EDGE_MODE, default 0, meaning 0 for level-sensitive set/reset and 1 for rising-edge-sensitive set/reset.
REQ-004 The block SHALL have parameter INIT, WIDTH bits, default all-zero, meaning the reset value of q.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-006 The block SHALL have the following ports:
- s  input  WIDTH  per-channel set request, active-high.
- r  input  WIDTH  per-channel reset request, active-high.
- clr_conflict  input  WIDTH  per-channel clear of the sticky conflict flag.
- q  output  WIDTH  registered channel state.
- qbar  output  WIDTH  complement of q.
- q_rise  output  WIDTH  one-cycle pulse, q went 0->1.
- q_fall  output  WIDTH  one-cycle pulse, q went 1->0.
- conflict  output  WIDTH  sticky flag, s and r were both effective on the channel.
- any_q  output  1  OR of q.
- ones_cnt  output  $clog2(WIDTH+1)  number of bits set in q.

Function
REQ-007 Effective set es[i] SHALL be s[i] when EDGE_MODE=0, and s[i] & ~s_d[i] when EDGE_MODE=1; effective reset er[i] likewise, with s_d/r_d being the previous-cycle samples.
REQ-008 On each rising clk edge, per channel: es & ~er -> q=1; er & ~es -> q=0; neither -> q holds.
REQ-009 When es & er, q SHALL become 0 (PRIORITY 0), 1 (PRIORITY 1), unchanged (PRIORITY 2), or ~q (PRIORITY 3).
REQ-010 Latency SHALL be one cycle: a request sampled at edge N is visible on q after edge N.
REQ-011 qbar SHALL equal ~q at all times; the invalid both-low state of a gate-level latch SHALL NOT exist.
REQ-012 q_rise/q_fall SHALL be registered and asserted for exactly the cycle in which q first shows the new value; a set on an already-set channel SHALL produce no pulse.
REQ-013 conflict[i] SHALL be set on the edge where es[i] & er[i] and cleared on an edge where clr_conflict[i]=1; a new conflict coinciding with clear SHALL leave the flag at 1.
REQ-014 any_q and ones_cnt SHALL be combinational from q, with ones_cnt = WIDTH when all bits are set.
REQ-015 Channels SHALL be fully independent; activity on one channel SHALL NOT affect another.

Reset
REQ-016 While rst=1 at a clk edge: q=INIT, q_rise=0, q_fall=0, conflict=0, s_d=0, r_d=0; rst SHALL override s, r and clr_conflict.
REQ-017 With EDGE_MODE=1, an s or r input held high through reset release SHALL count as a rising edge on the first edge after release.
REQ-018 Reset asserted mid-operation SHALL take effect at the next edge with no pulse generated on q_rise/q_fall for that transition.

Structure
REQ-019 Priority encodings (RESET_WINS, SET_WINS, HOLD, TOGGLE) SHALL be constants in shared package sr_bank_pkg.
REQ-020 One channel's q, edge detect, pulses and conflict flag SHALL be sub-module sr_cell, instantiated WIDTH times by generate; ones_cnt and any_q SHALL live in the top level.

Verification
REQ-021 Reset with INIT=8'hA5, then release -> q=8'hA5, qbar=8'h5A, ones_cnt=4, conflict=0, no pulses.
REQ-022 Level mode, s=8'h01 for one cycle, then r=8'h01 -> q[0] 0->1->0, q_rise[0] then q_fall[0] each one cycle.
REQ-023 s=r=8'hFF with each PRIORITY 0..3 from q=8'h0F -> q=8'h00 / 8'hFF / 8'h0F / 8'hF0; conflict=8'hFF.
REQ-024 EDGE_MODE=1, s[3] held high 10 cycles, r[3] pulsed at cycle 5 -> q[3] set at cycle 1, cleared at cycle 5, not re-set afterwards.
REQ-025 conflict[2]=1, clr_conflict[2] with simultaneous new conflict on channel 2 -> conflict[2] stays 1; clear alone next cycle -> 0.
REQ-026 rst pulse while q=8'hFF -> q=INIT after that edge, q_fall remains 0.

Source files
------------

// File: rtl/sr_bank_pkg.sv
// Shared constants for the set/reset flag bank: conflict-resolution modes,
// input sensitivity modes and the per-channel next-state resolver.
package sr_bank_pkg;

  localparam int RESET_WINS = 0;
  localparam int SET_WINS   = 1;
  localparam int HOLD       = 2;
  localparam int TOGGLE     = 3;

  localparam int LEVEL       = 0;
  localparam int RISING_EDGE = 1;

  // Next channel state from effective set/reset and the current state.
  function automatic logic resolve_next(input logic es, input logic er,
                                        input logic q, input int prio);
    logic nq;
    nq = q;
    if (es && !er) begin
      nq = 1'b1;
    end else if (er && !es) begin
      nq = 1'b0;
    end else if (es && er) begin
      case (prio)
        RESET_WINS: nq = 1'b0;
        SET_WINS:   nq = 1'b1;
        HOLD:       nq = q;
        TOGGLE:     nq = ~q;
        default:    nq = 1'b0;
      endcase
    end
    return nq;
  endfunction

endpackage

// File: rtl/sr_cell.sv
// One set/reset channel: optional rising-edge detection on s/r, registered
// state, registered transition pulses and a sticky conflict flag.
module sr_cell
  import sr_bank_pkg::*;
#(
  parameter int   PRIORITY  = RESET_WINS,
  parameter int   EDGE_MODE = LEVEL,
  parameter logic INIT      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  input  logic clr_conflict,
  output logic q,
  output logic q_rise,
  output logic q_fall,
  output logic conflict
);

  logic q_q, q_d;
  logic s_d_q, s_d_d;
  logic r_d_q, r_d_d;
  logic q_rise_q, q_rise_d;
  logic q_fall_q, q_fall_d;
  logic conflict_q, conflict_d;
  logic es, er;

  always_comb begin
    es         = s;
    er         = r;
    s_d_d      = s;
    r_d_d      = r;
    q_d        = q_q;
    q_rise_d   = 1'b0;
    q_fall_d   = 1'b0;
    conflict_d = conflict_q;

    if (EDGE_MODE == RISING_EDGE) begin
      es = s & ~s_d_q;
      er = r & ~r_d_q;
    end

    q_d      = resolve_next(es, er, q_q, PRIORITY);
    // Pulses are registered alongside q so they line up with the new value.
    q_rise_d = q_d & ~q_q;
    q_fall_d = ~q_d & q_q;
    // A fresh conflict beats a simultaneous clear.
    conflict_d = (es & er) | (conflict_q & ~clr_conflict);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q        <= INIT;
      s_d_q      <= 1'b0;
      r_d_q      <= 1'b0;
      q_rise_q   <= 1'b0;
      q_fall_q   <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      s_d_q      <= s_d_d;
      r_d_q      <= r_d_d;
      q_rise_q   <= q_rise_d;
      q_fall_q   <= q_fall_d;
      conflict_q <= conflict_d;
    end
  end

  assign q        = q_q;
  assign q_rise   = q_rise_q;
  assign q_fall   = q_fall_q;
  assign conflict = conflict_q;

endmodule

// File: rtl/sr_flag_bank.sv
// Bank of WIDTH independent set/reset flags with shared population count
// and any-set summary derived combinationally from q.
module sr_flag_bank
  import sr_bank_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               PRIORITY  = RESET_WINS,
  parameter int               EDGE_MODE = LEVEL,
  parameter logic [WIDTH-1:0] INIT      = '0,
  localparam int              CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] clr_conflict,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] q_rise,
  output logic [WIDTH-1:0] q_fall,
  output logic [WIDTH-1:0] conflict,
  output logic             any_q,
  output logic [CNT_W-1:0] ones_cnt
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_cell #(
      .PRIORITY  (PRIORITY),
      .EDGE_MODE (EDGE_MODE),
      .INIT      (INIT[i])
    ) u_cell (
      .clk          (clk),
      .rst          (rst),
      .s            (s[i]),
      .r            (r[i]),
      .clr_conflict (clr_conflict[i]),
      .q            (q[i]),
      .q_rise       (q_rise[i]),
      .q_fall       (q_fall[i]),
      .conflict     (conflict[i])
    );
  end

  assign qbar  = ~q;
  assign any_q = |q;

  always_comb begin
    ones_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones_cnt = ones_cnt + CNT_W'(q[i]);
    end
  end

endmodule

// File: tb/tb_sr_flag_bank.sv
// Directed bench for sr_flag_bank: four level-mode banks (one per priority)
// and one rising-edge bank, checked against a behavioural model every cycle.
module tb_sr_flag_bank;

  localparam int N = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s, r, clr;

  logic [7:0] q_o[N], qbar_o[N], rise_o[N], fall_o[N], conf_o[N];
  logic       any_o[N];
  logic [3:0] cnt_o[N];

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  int         prio_m[N] = '{0, 1, 2, 3, 0};
  bit         edge_m[N] = '{0, 0, 0, 0, 1};
  logic [7:0] init_m[N] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00};

  logic [7:0] mq[N], mrise[N], mfall[N], mconf[N], msd[N], mrd[N];

  always #5 clk = ~clk;

  sr_flag_bank #(.WIDTH(8), .PRIORITY(0), .EDGE_MODE(0), .INIT(8'hA5)) u_p0 (
    .clk(clk), .rst(rst), .s(s), .r(r), .clr_conflict(clr),
    .q(q_o[0]), .qbar(qbar_o[0]), .q_rise(rise_o[0]), .q_fall(fall_o[0]),
    .conflict(conf_o[0]), .any_q(any_o[0]), .ones_cnt(cnt_o[0]));
  sr_flag_bank #(.WIDTH(8), .PRIORITY(1), .EDGE_MODE(0), .INIT(8'hA5)) u_p1 (
    .clk(clk), .rst(rst), .s(s), .r(r), .clr_conflict(clr),
    .q(q_o[1]), .qbar(qbar_o[1]), .q_rise(rise_o[1]), .q_fall(fall_o[1]),
    .conflict(conf_o[1]), .any_q(any_o[1]), .ones_cnt(cnt_o[1]));
  sr_flag_bank #(.WIDTH(8), .PRIORITY(2), .EDGE_MODE(0), .INIT(8'hA5)) u_p2 (
    .clk(clk), .rst(rst), .s(s), .r(r), .clr_conflict(clr),
    .q(q_o[2]), .qbar(qbar_o[2]), .q_rise(rise_o[2]), .q_fall(fall_o[2]),
    .conflict(conf_o[2]), .any_q(any_o[2]), .ones_cnt(cnt_o[2]));
  sr_flag_bank #(.WIDTH(8), .PRIORITY(3), .EDGE_MODE(0), .INIT(8'hA5)) u_p3 (
    .clk(clk), .rst(rst), .s(s), .r(r), .clr_conflict(clr),
    .q(q_o[3]), .qbar(qbar_o[3]), .q_rise(rise_o[3]), .q_fall(fall_o[3]),
    .conflict(conf_o[3]), .any_q(any_o[3]), .ones_cnt(cnt_o[3]));
  sr_flag_bank #(.WIDTH(8), .PRIORITY(0), .EDGE_MODE(1), .INIT(8'h00)) u_e0 (
    .clk(clk), .rst(rst), .s(s), .r(r), .clr_conflict(clr),
    .q(q_o[4]), .qbar(qbar_o[4]), .q_rise(rise_o[4]), .q_fall(fall_o[4]),
    .conflict(conf_o[4]), .any_q(any_o[4]), .ones_cnt(cnt_o[4]));

  // Reference model: per-channel set/reset rules applied to the sampled inputs.
  always @(posedge clk) begin
    logic [7:0] nq, ri, fa, cf;
    bit es, er;
    for (int k = 0; k < N; k++) begin
      if (rst) begin
        mq[k] <= init_m[k];
        mrise[k] <= 8'h00; mfall[k] <= 8'h00; mconf[k] <= 8'h00;
        msd[k] <= 8'h00; mrd[k] <= 8'h00;
      end else begin
        for (int i = 0; i < 8; i++) begin
          es = edge_m[k] ? (s[i] && !msd[k][i]) : s[i];
          er = edge_m[k] ? (r[i] && !mrd[k][i]) : r[i];
          if (es && er) begin
            case (prio_m[k])
              0: nq[i] = 1'b0;
              1: nq[i] = 1'b1;
              2: nq[i] = mq[k][i];
              default: nq[i] = !mq[k][i];
            endcase
            cf[i] = 1'b1;
          end else begin
            nq[i] = es ? 1'b1 : (er ? 1'b0 : mq[k][i]);
            cf[i] = clr[i] ? 1'b0 : mconf[k][i];
          end
          ri[i] = nq[i] && !mq[k][i];
          fa[i] = !nq[i] && mq[k][i];
        end
        mq[k] <= nq; mrise[k] <= ri; mfall[k] <= fa; mconf[k] <= cf;
        msd[k] <= s; mrd[k] <= r;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < N; k++) begin
        checkOutput($sformatf("q[%0d]", k), q_o[k], mq[k]);
        checkOutput($sformatf("qbar[%0d]", k), qbar_o[k], ~mq[k]);
        checkOutput($sformatf("q_rise[%0d]", k), rise_o[k], mrise[k]);
        checkOutput($sformatf("q_fall[%0d]", k), fall_o[k], mfall[k]);
        checkOutput($sformatf("conflict[%0d]", k), conf_o[k], mconf[k]);
        checkOutput($sformatf("any_q[%0d]", k), {7'd0, any_o[k]}, {7'd0, |mq[k]});
        checkOutput($sformatf("ones_cnt[%0d]", k), {4'd0, cnt_o[k]}, 8'($countones(mq[k])));
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] sv, input logic [7:0] rv,
                               input logic [7:0] cv, input logic rstv);
    s = sv; r = rv; clr = cv; rst = rstv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    s = 8'h00; r = 8'h00; clr = 8'h00; rst = 1'b1;
    #1;
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b1);
    chk_en = 1;
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b1);
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b0);
    checkOutput("init_q", q_o[0], 8'hA5);
    checkOutput("init_qbar", qbar_o[0], 8'h5A);
    checkOutput("init_cnt", {4'd0, cnt_o[0]}, 8'd4);
    checkOutput("init_conf", conf_o[0], 8'h00);
    checkOutput("init_rise", rise_o[0] | fall_o[0], 8'h00);

    applyStimulus(8'h00, 8'h01, 8'h00, 1'b0);
    checkOutput("clr_bit0", q_o[0], 8'hA4);
    applyStimulus(8'h01, 8'h00, 8'h00, 1'b0);
    checkOutput("set_q", q_o[0], 8'hA5);
    checkOutput("set_rise", rise_o[0], 8'h01);
    applyStimulus(8'h00, 8'h01, 8'h00, 1'b0);
    checkOutput("rst_q", q_o[0], 8'hA4);
    checkOutput("rst_fall", fall_o[0], 8'h01);
    checkOutput("rst_rise", rise_o[0], 8'h00);
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b0);
    checkOutput("fall_once", fall_o[0], 8'h00);

    applyStimulus(8'h0F, 8'hF0, 8'h00, 1'b0);
    checkOutput("pre_0F", q_o[3], 8'h0F);
    applyStimulus(8'hFF, 8'hFF, 8'h00, 1'b0);
    checkOutput("prio_reset", q_o[0], 8'h00);
    checkOutput("prio_set", q_o[1], 8'hFF);
    checkOutput("prio_hold", q_o[2], 8'h0F);
    checkOutput("prio_toggle", q_o[3], 8'hF0);
    checkOutput("prio_conf", conf_o[2], 8'hFF);

    applyStimulus(8'h04, 8'h04, 8'h04, 1'b0);
    checkOutput("conf_keep", conf_o[0], 8'hFF);
    applyStimulus(8'h00, 8'h00, 8'h04, 1'b0);
    checkOutput("conf_clear", conf_o[0], 8'hFB);

    applyStimulus(8'hFF, 8'h00, 8'h00, 1'b0);
    checkOutput("all_set", q_o[0], 8'hFF);
    checkOutput("all_cnt", {4'd0, cnt_o[0]}, 8'd8);
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b1);
    checkOutput("midrst_q", q_o[0], 8'hA5);
    checkOutput("midrst_fall", fall_o[0], 8'h00);

    // s[3] held through reset release, then r[3] pulsed on the fifth cycle.
    applyStimulus(8'h08, 8'h00, 8'h00, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      applyStimulus(8'h08, (c == 5) ? 8'h08 : 8'h00, 8'h00, 1'b0);
      if (c == 1) checkOutput("edge_set", q_o[4], 8'h08);
      if (c == 5) checkOutput("edge_clr", q_o[4], 8'h00);
    end
    checkOutput("edge_noreset", q_o[4], 8'h00);

    for (int c = 0; c < 40; c++) begin
      applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 15) == 0));
    end

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
